pipeline_interlock: RTL and testbench

- Hazard and stall controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Detects read-after-write hazards between the instruction in ID and the destinations in EX, MEM and WB, and inserts bubbles until the hazard clears.
- Sequences the multi-cycle multiplier: freezes IF, ID and EX for a fixed number of core-clock cycles per multiply.
- Sits beside the control unit. Drives the PC/IF-ID hold, ID/EX bubble/hold and EX/MEM bubble enables.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipeline_interlock_if.sv | 48 ++++
 rtl/raw_detect.sv | 43 ++++
 rtl/pipeline_interlock.sv | 159 +++++++++++++++
 tb/tb_pipeline_interlock.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline interlock.
//   - state encoding of the interlock FSM
//   - register-index width
//   - NOP control word (all control bits cleared) used when a bubble is loaded
//   - reg_match(): one destination-vs-source RAW comparison
package pipe_pkg;

  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;

  localparam logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}};

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  // Register 0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src,
                                     input logic             wr);
    return wr & (dst == src) & (src != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/pipeline_interlock_if.sv
// Bundle between the control unit / pipeline registers and the interlock.
//   ID instruction info : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_mul
//   stage destinations  : ex_rd/ex_wr, mem_rd/mem_wr, wb_rd/wb_wr
//   interlock controls  : stall_if, bubble_ex, hold_ex, bubble_mem,
//                         mul_start, mul_busy, stall_cycles
// master = pipeline side (drives instruction info), slave = interlock.
interface pipeline_interlock_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_mul;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] mem_rd;
  logic [REG_W-1:0] wb_rd;
  logic             ex_wr;
  logic             mem_wr;
  logic             wb_wr;

  logic             stall_if;
  logic             bubble_ex;
  logic             hold_ex;
  logic             bubble_mem;
  logic             mul_start;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_mul,
    output ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr,
    input  stall_if, bubble_ex, hold_ex, bubble_mem, mul_start, mul_busy,
    input  stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_mul,
    input  ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr,
    output stall_if, bubble_ex, hold_ex, bubble_mem, mul_start, mul_busy,
    output stall_cycles
  );

endinterface

// File: rtl/raw_detect.sv
// Combinational RAW comparator for one ID source register against the
// destinations in EX, MEM and WB.
//   src, uses           : source register index and its read-enable
//   *_rd, *_wr          : destination index and write enable per stage
//   haz                 : source depends on an in-flight write
// With WB_BYPASS=1 the register file forwards same-cycle writes, so a WB
// match is resolved without stalling.
module raw_detect
  import pipe_pkg::*;
#(
  parameter int WB_BYPASS = 0
) (
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wr,
  output logic             haz
);

  logic wb_term_s;

  // WB comparison, suppressed when the register file bypasses the write.
  always_comb begin
    wb_term_s = 1'b0;
    if (WB_BYPASS == 0) begin
      wb_term_s = reg_match(wb_rd, src, wb_wr);
    end else begin
      wb_term_s = 1'b0;
    end
  end

  // Combine the three stage comparisons, gated by actual use of the source.
  always_comb begin
    haz = uses & (reg_match(ex_rd, src, ex_wr) |
                  reg_match(mem_rd, src, mem_wr) |
                  wb_term_s);
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Hazard and stall controller for the 5-stage pipeline.
//   clk  : core clock
//   rst  : asynchronous active-low reset; forces every output to 0
//   bus  : pipeline_interlock_if.slave (ID info, stage destinations in;
//          stall/bubble/hold enables, multiplier control, stall counter out)
// RAW hazards on rs/rt insert ID/EX bubbles while holding IF. A multiply
// freezes IF/ID/EX for MUL_CYCLES-1 cycles and releases in its last EX cycle
// so EX/MEM captures the product.
module pipeline_interlock
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = 34,
  parameter int WB_BYPASS  = 0,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_interlock_if.slave bus
);

  localparam logic [7:0] CNT_INIT  = 8'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  logic             haz_rs_s;
  logic             haz_rt_s;
  logic             raw_s;
  logic             issue_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [7:0]       cnt_r;
  logic [7:0]       cnt_nxt_s;
  logic             start_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic stall_if_s;
  logic bubble_ex_s;
  logic hold_ex_s;
  logic bubble_mem_s;
  logic mul_busy_s;

  raw_detect #(.WB_BYPASS(WB_BYPASS)) u_raw_rs (
    .src    (bus.id_rs),
    .uses   (bus.id_uses_rs),
    .ex_rd  (bus.ex_rd),
    .ex_wr  (bus.ex_wr),
    .mem_rd (bus.mem_rd),
    .mem_wr (bus.mem_wr),
    .wb_rd  (bus.wb_rd),
    .wb_wr  (bus.wb_wr),
    .haz    (haz_rs_s)
  );

  raw_detect #(.WB_BYPASS(WB_BYPASS)) u_raw_rt (
    .src    (bus.id_rt),
    .uses   (bus.id_uses_rt),
    .ex_rd  (bus.ex_rd),
    .ex_wr  (bus.ex_wr),
    .mem_rd (bus.mem_rd),
    .mem_wr (bus.mem_wr),
    .wb_rd  (bus.wb_rd),
    .wb_wr  (bus.wb_wr),
    .haz    (haz_rt_s)
  );

  assign raw_s = bus.id_valid & (haz_rs_s | haz_rt_s);

  // Next-state and stall decode; MUL_WAIT ignores raw because ID is frozen.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    issue_s      = 1'b0;
    stall_if_s   = 1'b0;
    bubble_ex_s  = 1'b0;
    hold_ex_s    = 1'b0;
    bubble_mem_s = 1'b0;
    mul_busy_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (raw_s) begin
          stall_if_s  = 1'b1;
          bubble_ex_s = 1'b1;
        end else if (bus.id_valid && bus.id_mul) begin
          issue_s = 1'b1;
          // A single-cycle multiply flows like an ALU op: no wait state.
          if (MUL_MULTI) begin
            state_nxt_s = MUL_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_WAIT: begin
        mul_busy_s = 1'b1;
        if (cnt_r != 8'd0) begin
          stall_if_s   = 1'b1;
          hold_ex_s    = 1'b1;
          bubble_mem_s = 1'b1;
          cnt_nxt_s    = cnt_r - 8'd1;
        end else begin
          // Last EX cycle: release everything so EX/MEM takes the product.
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // FSM state, countdown and the one-cycle start pulse (EX cycle of the multiply).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      start_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      start_r <= issue_s;
    end
  end

  // Saturating count of cycles in which IF was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_if_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Output gating: the combinational RAW path must also drop during reset.
  always_comb begin
    if (!rst) begin
      bus.stall_if     = 1'b0;
      bus.bubble_ex    = 1'b0;
      bus.hold_ex      = 1'b0;
      bus.bubble_mem   = 1'b0;
      bus.mul_start    = 1'b0;
      bus.mul_busy     = 1'b0;
      bus.stall_cycles = {CNT_W{1'b0}};
    end else begin
      bus.stall_if     = stall_if_s;
      bus.bubble_ex    = bubble_ex_s;
      bus.hold_ex      = hold_ex_s;
      bus.bubble_mem   = bubble_mem_s;
      bus.mul_start    = start_r;
      bus.mul_busy     = mul_busy_s;
      bus.stall_cycles = stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Scoreboard bench for pipeline_interlock (MUL_CYCLES=34, WB_BYPASS=0).
// Each step drives inputs after a rising edge, pushes the expected outputs,
// and pops/compares them on the falling edge.
module tb_pipeline_interlock;

  logic clk;
  logic rst;

  pipeline_interlock_if #(.CNT_W(16)) bus ();

  pipeline_interlock #(
    .MUL_CYCLES (34),
    .WB_BYPASS  (0),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [5:0]  outs;   // {stall_if, bubble_ex, hold_ex, bubble_mem, mul_start, mul_busy}
    logic [15:0] sc;
  } sb_t;

  sb_t         sb_q[$];
  int          checks;
  int          errors;
  logic [15:0] exp_sc;

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_RAW   = 6'b110000;
  localparam logic [5:0] E_MUL1  = 6'b101111;
  localparam logic [5:0] E_MULW  = 6'b101101;
  localparam logic [5:0] E_MULL  = 6'b000001;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mul,
                       input logic [4:0] exd, input logic exw,
                       input logic [4:0] md, input logic mw,
                       input logic [4:0] wd, input logic ww);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_mul     = mul;
    bus.ex_rd      = exd;
    bus.ex_wr      = exw;
    bus.mem_rd     = md;
    bus.mem_wr     = mw;
    bus.wb_rd      = wd;
    bus.wb_wr      = ww;
  endtask

  task automatic push_exp(input string tag, input logic [5:0] e);
    sb_t it;
    it.tag  = tag;
    it.outs = e;
    it.sc   = exp_sc;
    sb_q.push_back(it);
  endtask

  task automatic compare_front();
    sb_t it;
    logic [5:0] obs;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 expected 1");
    end else begin
      it  = sb_q.pop_front();
      obs = {bus.stall_if, bus.bubble_ex, bus.hold_ex, bus.bubble_mem,
             bus.mul_start, bus.mul_busy};
      check_eq({it.tag, ".stall_if"},   32'(obs[5]), 32'(it.outs[5]));
      check_eq({it.tag, ".bubble_ex"},  32'(obs[4]), 32'(it.outs[4]));
      check_eq({it.tag, ".hold_ex"},    32'(obs[3]), 32'(it.outs[3]));
      check_eq({it.tag, ".bubble_mem"}, 32'(obs[2]), 32'(it.outs[2]));
      check_eq({it.tag, ".mul_start"},  32'(obs[1]), 32'(it.outs[1]));
      check_eq({it.tag, ".mul_busy"},   32'(obs[0]), 32'(it.outs[0]));
      check_eq({it.tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(it.sc));
    end
  endtask

  // One clock cycle: inputs already driven; compare mid-cycle, then advance.
  task automatic step(input string tag, input logic [5:0] e);
    push_exp(tag, e);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    if (e[5] && rst && (exp_sc != 16'hFFFF)) exp_sc = exp_sc + 16'd1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_sc = 16'd0;
    rst    = 1'b0;
    // Hazard-looking inputs during reset: outputs must still be 0.
    apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    step("reset", E_NONE);
    step("reset_hold", E_NONE);
    rst = 1'b1;

    // Independent ops.
    apply(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("indep", E_NONE);
    step("indep2", E_NONE);

    // RAW from EX, then as the producer walks through MEM and WB.
    apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("raw_ex", E_RAW);
    apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    step("raw_mem", E_RAW);
    apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    step("raw_wb", E_RAW);
    apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("raw_clear", E_NONE);

    // Register 0, masked use, and an rt dependency through WB.
    apply(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    step("reg0", E_NONE);
    apply(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    step("rt_masked", E_NONE);
    apply(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step("rt_wb", E_RAW);
    apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("invalid_id", E_NONE);

    // Multiply, 34 cycles in EX; raw against the multiply's rd is ignored meanwhile.
    apply(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mul_issue", E_NONE);
    apply(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mul_first", E_MUL1);
    for (int i = 0; i < 32; i++) step("mul_wait", E_MULW);
    step("mul_last", E_MULL);
    apply(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    step("mul_dep", E_RAW);
    apply(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mul_done", E_NONE);

    // RAW takes precedence over a pending multiply issue.
    apply(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rawmul_raw", E_RAW);
    apply(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rawmul_issue", E_NONE);
    apply(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rawmul_first", E_MUL1);
    for (int i = 0; i < 8; i++) step("rawmul_wait", E_MULW);

    // Asynchronous reset in the 10th multiply cycle, checked before any edge.
    #1;
    rst    = 1'b0;
    exp_sc = 16'd0;
    #1;
    push_exp("async_rst", E_NONE);
    compare_front();
    @(posedge clk);
    #1;
    step("rst_held", E_NONE);
    rst = 1'b1;
    apply(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("post_rst_idle", E_NONE);
    apply(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("post_rst_issue", E_NONE);
    apply(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("post_rst_first", E_MUL1);
    step("post_rst_wait", E_MULW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
